cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 28, word address width; DATA_WIDTH, default 32, CPU word width; BLOCK_SIZE, default 256, line width in bits; INDEX_WIDTH, default 11, line index width; OFFSET_WIDTH, default 3, word-in-line select width; TAG_WIDTH, default ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (14).
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, all state on posedge
 rst  in  1  asynchronous, active-high reset
 cpu_req  in  1  CPU access request, held until cpu_ready
 cpu_we  in  1  1 = write, 0 = read
 cpu_addr  in  ADDR_WIDTH  word address {tag,index,offset}
 cpu_wdata  in  DATA_WIDTH  write word
 cpu_rdata  out  DATA_WIDTH  read word
 cpu_ready  out  1  one-cycle completion pulse
 cache_addr  out  ADDR_WIDTH  address to cache array
 cache_wdata  out  BLOCK_SIZE  line to write
 cache_dirty_wr  out  1  dirty bit to write
 cache_we  out  1  cache line write enable
 cache_rdata  in  BLOCK_SIZE  line read from array
 cache_dirty  in  1  dirty bit of indexed line
 cache_hit  in  1  valid and tag match
 cache_valid  in  1  indexed line valid
 cache_tag  in  TAG_WIDTH  resident tag of indexed line
 mem_req  out  1  memory request, held until mem_ready
 mem_we  out  1  1 = line write-back, 0 = line fetch
 mem_addr  out  ADDR_WIDTH  line-aligned address, offset bits zero
 mem_wdata  out  BLOCK_SIZE  write-back line
 mem_rdata  in  BLOCK_SIZE  fetched line
 mem_ready  in  1  memory completion, one cycle
 hit_count  out  16  saturating hit counter
 miss_count  out  16  saturating miss counter

Function
REQ-003 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE.
REQ-004 IDLE: when cpu_req=1 and cpu_ready=0, SHALL latch cpu_addr, cpu_we, cpu_wdata and go to LOOKUP; otherwise stay.
REQ-005 cache_addr SHALL equal the latched address in every non-IDLE state; the array's negedge read is consumed at the LOOKUP-exit posedge.
REQ-006 LOOKUP (one cycle): on cache_hit with read, SHALL load cpu_rdata with word [offset] and go to IDLE with cpu_ready set; on hit with write, go to UPDATE; on miss with cache_valid and cache_dirty, latch cache_tag and cache_rdata and go to WRITEBACK; otherwise go to REFILL.
REQ-007 WRITEBACK: mem_req=1, mem_we=1, mem_addr={latched resident tag, index, zeros}, mem_wdata=latched line; on mem_ready SHALL go to REFILL.
REQ-008 REFILL: mem_req=1, mem_we=0, mem_addr={request tag, index, zeros}; on mem_ready SHALL capture mem_rdata into the line buffer and go to UPDATE.
REQ-009 UPDATE (one cycle): cache_we=1; cache_wdata=buffered line (hit: cache_rdata) with word [offset] replaced by cpu_wdata when write; cache_dirty_wr=1 for write, 0 for read-miss; cpu_rdata SHALL load word [offset] of the written line; SHALL go to IDLE with cpu_ready set.
REQ-010 Word i SHALL occupy line bits [DATA_WIDTH*i+DATA_WIDTH-1 : DATA_WIDTH*i].
REQ-011 cpu_ready SHALL be registered, high exactly one cycle; cpu_rdata SHALL hold until the next completion.
REQ-012 Latency from accept edge to cpu_ready-set edge: read hit 1 edge, write hit 2 edges, miss = 2 + memory wait edges (+ write-back wait when dirty).
REQ-013 mem_ready outside WRITEBACK/REFILL SHALL be ignored; CPU inputs SHALL be ignored outside IDLE.
REQ-014 cache_we SHALL be 0 in every state except UPDATE; mem_req SHALL be 0 except WRITEBACK/REFILL.
REQ-015 hit_count SHALL increment at LOOKUP exit on hit, miss_count on miss; both SHALL saturate at 16'hFFFF.

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE and clear cpu_ready, cpu_rdata, cache_we, cache_dirty_wr, mem_req, mem_we, hit_count, miss_count and all latches to 0.
REQ-017 Reset mid-transaction SHALL abandon it; no cache write or cpu_ready SHALL follow, and a late mem_ready SHALL be ignored.

Verification
REQ-018 Read hit: line at index 5 holds word3=32'hDEADBEEF, read addr with offset 3 -> cpu_ready one edge after accept, cpu_rdata=32'hDEADBEEF, hit_count=1, mem_req never high.
REQ-019 Write hit: write 32'h12345678 to offset 0 of a resident clean line -> one UPDATE cycle, cache_we=1, cache_dirty_wr=1, word0 replaced, other words unchanged.
REQ-020 Clean miss: read, cache_valid=0, memory responds after 4 cycles with line of word i = i -> single fetch with mem_we=0, cpu_rdata = offset value, miss_count=1.
REQ-021 Dirty miss: resident tag 14'h0AB dirty, request tag 14'h0CD same index -> write-back to {14'h0AB,index,3'b0} first, then fetch {14'h0CD,index,3'b0}, UPDATE with cache_dirty_wr=cpu_we.
REQ-022 Reset asserted during REFILL, then mem_ready pulse -> mem_req drops immediately, IDLE, no cache_we, no cpu_ready, counters 0.
REQ-023 Counter saturation: preload 16'hFFFF hits via repeated read hits -> hit_count stays 16'hFFFF after one more hit.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: write-back, write-allocate cache controller FSM with saturating hit/miss counters
module cache_controller #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 256,
  parameter int INDEX_WIDTH  = 11,
  parameter int OFFSET_WIDTH = 3,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [BLOCK_SIZE-1:0] cache_wdata,
  output logic                  cache_dirty_wr,
  output logic                  cache_we,
  input  logic [BLOCK_SIZE-1:0] cache_rdata,
  input  logic                  cache_dirty,
  input  logic                  cache_hit,
  input  logic                  cache_valid,
  input  logic [TAG_WIDTH-1:0]  cache_tag,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BLOCK_SIZE-1:0] line_buf, new_line;
  logic [TAG_WIDTH-1:0] wb_tag, req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [OFFSET_WIDTH-1:0] req_off;
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_off = req_addr[OFFSET_WIDTH-1:0];
  always_comb begin
    new_line = line_buf;
    if (req_we) new_line[req_off*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = cpu_req && !cpu_ready ? LOOKUP : IDLE;
      LOOKUP:    state_nx = cache_hit ? (req_we ? UPDATE : IDLE) : (cache_valid && cache_dirty ? WRITEBACK : REFILL);
      WRITEBACK: state_nx = mem_ready ? REFILL : WRITEBACK;
      REFILL:    state_nx = mem_ready ? UPDATE : REFILL;
      default:   state_nx = IDLE;
    endcase
  end
  assign cache_addr     = req_addr;
  assign cache_we       = state == UPDATE;
  assign cache_dirty_wr = state == UPDATE && req_we;
  assign cache_wdata    = new_line;
  assign mem_req        = state == WRITEBACK || state == REFILL;
  assign mem_we         = state == WRITEBACK;
  assign mem_addr       = {state == WRITEBACK ? wb_tag : req_tag, req_idx, {OFFSET_WIDTH{1'b0}}};
  assign mem_wdata      = line_buf;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // line_buf doubles as write-back source and refill target; a hit preloads it with the resident line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      line_buf   <= '0;
      wb_tag     <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: if (cpu_req && !cpu_ready) begin
          req_addr  <= cpu_addr;
          req_we    <= cpu_we;
          req_wdata <= cpu_wdata;
        end
        LOOKUP: begin
          line_buf   <= cache_rdata;
          wb_tag     <= cache_tag;
          hit_count  <= hit_count + 16'(cache_hit && hit_count != 16'hFFFF);
          miss_count <= miss_count + 16'(!cache_hit && miss_count != 16'hFFFF);
          if (cache_hit && !req_we) begin
            cpu_rdata <= cache_rdata[req_off*DATA_WIDTH +: DATA_WIDTH];
            cpu_ready <= 1'b1;
          end
        end
        REFILL: if (mem_ready) line_buf <= mem_rdata;
        UPDATE: begin
          cpu_rdata <= new_line[req_off*DATA_WIDTH +: DATA_WIDTH];
          cpu_ready <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed self-checking bench; the bench plays both cache array and memory
module tb_cache_controller;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0;
  logic [27:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic cpu_ready;
  logic [27:0] cache_addr, mem_addr;
  logic [255:0] cache_wdata, mem_wdata;
  logic cache_dirty_wr, cache_we, mem_req, mem_we;
  logic [255:0] cache_rdata = '0, mem_rdata = '0;
  logic cache_dirty = 0, cache_hit = 0, cache_valid = 0, mem_ready = 0;
  logic [13:0] cache_tag = '0;
  logic [15:0] hit_count, miss_count;
  int n_cmp = 0, n_bad = 0;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_dirty_wr(cache_dirty_wr),
    .cache_we(cache_we), .cache_rdata(cache_rdata), .cache_dirty(cache_dirty),
    .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_tag(cache_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if ({cache_we, cache_dirty_wr, mem_req, mem_we} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {cache_we, cache_dirty_wr, mem_req, mem_we}); end
    n_cmp++; if ({hit_count, miss_count} !== 32'h0) begin n_bad++; $display("FAIL reset_counts: got %h/%h want 0/0", hit_count, miss_count); end
    rst = 0;
  endtask

  task automatic test_read_hit;
    logic [27:0] a;
    logic [255:0] ln;
    a = {14'h012, 11'd5, 3'd3};
    ln = mk_line(32'h1000_0000);
    ln[96 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    cache_hit = 1; cache_valid = 1; cache_dirty = 0; cache_tag = 14'h012; cache_rdata = ln;
    cpu_we = 0; cpu_addr = a; cpu_req = 1;
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rdhit_early_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (cache_addr !== a) begin n_bad++; $display("FAIL rdhit_cache_addr: got %h want %h", cache_addr, a); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdhit_mem_req_lookup: got %b want 0", mem_req); end
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rdhit_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdhit_rdata: got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (hit_count !== 16'd1) begin n_bad++; $display("FAIL rdhit_hit_count: got %0d want 1", hit_count); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rdhit_mem_req_done: got %b want 0", mem_req); end
    cpu_req = 0;
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rdhit_ready_pulse: got %b want 0", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdhit_rdata_hold: got %h want deadbeef", cpu_rdata); end
  endtask

  task automatic test_write_hit;
    logic [27:0] a;
    logic [255:0] ln, exp;
    a = {14'h021, 11'd7, 3'd0};
    ln = mk_line(32'h2000_0000);
    exp = ln;
    exp[31:0] = 32'h12345678;
    @(negedge clk);
    cache_hit = 1; cache_valid = 1; cache_dirty = 0; cache_tag = 14'h021; cache_rdata = ln;
    cpu_we = 1; cpu_addr = a; cpu_wdata = 32'h12345678; cpu_req = 1;
    @(negedge clk);
    cpu_addr = 28'hFFFFFFF; cpu_wdata = 32'hBAD0BAD0;
    n_cmp++; if (cache_we !== 1'b0) begin n_bad++; $display("FAIL wrhit_we_lookup: got %b want 0", cache_we); end
    @(negedge clk);
    n_cmp++; if (cache_we !== 1'b1) begin n_bad++; $display("FAIL wrhit_we_update: got %b want 1", cache_we); end
    n_cmp++; if (cache_dirty_wr !== 1'b1) begin n_bad++; $display("FAIL wrhit_dirty: got %b want 1", cache_dirty_wr); end
    n_cmp++; if (cache_wdata !== exp) begin n_bad++; $display("FAIL wrhit_wdata: got %h want %h", cache_wdata, exp); end
    n_cmp++; if (cache_addr !== a) begin n_bad++; $display("FAIL wrhit_cache_addr: got %h want %h", cache_addr, a); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL wrhit_early_ready: got %b want 0", cpu_ready); end
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL wrhit_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL wrhit_rdata: got %h want 12345678", cpu_rdata); end
    n_cmp++; if (cache_we !== 1'b0) begin n_bad++; $display("FAIL wrhit_we_after: got %b want 0", cache_we); end
    n_cmp++; if (hit_count !== 16'd2) begin n_bad++; $display("FAIL wrhit_hit_count: got %0d want 2", hit_count); end
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
  endtask

  task automatic test_clean_miss;
    logic [27:0] a;
    a = {14'h033, 11'd9, 3'd6};
    @(negedge clk);
    cache_hit = 0; cache_valid = 0; cache_dirty = 1; cache_tag = 14'h3FF; cache_rdata = '1;
    cpu_we = 0; cpu_addr = a; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 0;
    n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL cmiss_miss_count: got %0d want 1", miss_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({mem_req, mem_we} !== 2'b10) begin n_bad++; $display("FAIL cmiss_fetch_%0d: got req/we %b want 10", i, {mem_req, mem_we}); end
      n_cmp++; if (mem_addr !== {14'h033, 11'd9, 3'd0}) begin n_bad++; $display("FAIL cmiss_addr_%0d: got %h want %h", i, mem_addr, {14'h033, 11'd9, 3'd0}); end
      if (i == 3) begin mem_ready = 1; mem_rdata = mk_line(32'h0); end
      @(negedge clk);
    end
    mem_ready = 0; mem_rdata = '0;
    n_cmp++; if ({cache_we, cache_dirty_wr, mem_req} !== 3'b100) begin n_bad++; $display("FAIL cmiss_update: got we/dirty/req %b want 100", {cache_we, cache_dirty_wr, mem_req}); end
    n_cmp++; if (cache_wdata !== mk_line(32'h0)) begin n_bad++; $display("FAIL cmiss_wdata: got %h want %h", cache_wdata, mk_line(32'h0)); end
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL cmiss_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'd6) begin n_bad++; $display("FAIL cmiss_rdata: got %h want 6", cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_dirty_miss;
    logic [27:0] a;
    logic [255:0] old_ln, new_ln, exp;
    a = {14'h0CD, 11'h123, 3'd2};
    old_ln = mk_line(32'hA0);
    new_ln = mk_line(32'h500);
    exp = new_ln;
    exp[64 +: 32] = 32'hCAFEF00D;
    @(negedge clk);
    cache_hit = 0; cache_valid = 1; cache_dirty = 1; cache_tag = 14'h0AB; cache_rdata = old_ln;
    cpu_we = 1; cpu_addr = a; cpu_wdata = 32'hCAFEF00D; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 0; cache_rdata = '0; cache_tag = '0;
    n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin n_bad++; $display("FAIL dmiss_wb_ctrl: got req/we %b want 11", {mem_req, mem_we}); end
    n_cmp++; if (mem_addr !== {14'h0AB, 11'h123, 3'd0}) begin n_bad++; $display("FAIL dmiss_wb_addr: got %h want %h", mem_addr, {14'h0AB, 11'h123, 3'd0}); end
    @(negedge clk);
    n_cmp++; if (mem_wdata !== old_ln) begin n_bad++; $display("FAIL dmiss_wb_data: got %h want %h", mem_wdata, old_ln); end
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    n_cmp++; if ({mem_req, mem_we} !== 2'b10) begin n_bad++; $display("FAIL dmiss_fetch_ctrl: got req/we %b want 10", {mem_req, mem_we}); end
    n_cmp++; if (mem_addr !== {14'h0CD, 11'h123, 3'd0}) begin n_bad++; $display("FAIL dmiss_fetch_addr: got %h want %h", mem_addr, {14'h0CD, 11'h123, 3'd0}); end
    mem_ready = 1; mem_rdata = new_ln;
    @(negedge clk);
    mem_ready = 0; mem_rdata = '0;
    n_cmp++; if ({cache_we, cache_dirty_wr} !== 2'b11) begin n_bad++; $display("FAIL dmiss_update: got we/dirty %b want 11", {cache_we, cache_dirty_wr}); end
    n_cmp++; if (cache_wdata !== exp) begin n_bad++; $display("FAIL dmiss_wdata: got %h want %h", cache_wdata, exp); end
    @(negedge clk);
    n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL dmiss_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL dmiss_rdata: got %h want cafef00d", cpu_rdata); end
    n_cmp++; if (miss_count !== 16'd2) begin n_bad++; $display("FAIL dmiss_miss_count: got %0d want 2", miss_count); end
    cpu_we = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cache_hit = 0; cache_valid = 0; cache_dirty = 0;
    cpu_we = 0; cpu_addr = {14'h044, 11'd3, 3'd1}; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 0;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_in_refill: got %b want 1", mem_req); end
    @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_req_drop: got %b want 0", mem_req); end
    n_cmp++; if ({hit_count, miss_count} !== 32'h0) begin n_bad++; $display("FAIL rmid_counts: got %h/%h want 0/0", hit_count, miss_count); end
    @(negedge clk);
    rst = 0;
    mem_ready = 1; mem_rdata = '1;
    @(negedge clk);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({cache_we, cpu_ready, mem_req} !== 3'b000) begin n_bad++; $display("FAIL rmid_quiet_%0d: got we/ready/req %b want 000", i, {cache_we, cpu_ready, mem_req}); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation;
    force dut.hit_count = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count;
    cache_hit = 1; cache_valid = 1; cache_dirty = 0; cache_tag = 14'h001; cache_rdata = mk_line(32'h0);
    for (int i = 0; i < 2; i++) begin
      cpu_we = 0; cpu_addr = {14'h001, 11'd0, 3'd1}; cpu_req = 1;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 0;
      n_cmp++; if (hit_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hit_%0d: got %h want ffff", i, hit_count); end
      n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready_%0d: got %b want 1", i, cpu_ready); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_read_hit;
    test_write_hit;
    test_clean_miss;
    test_dirty_miss;
    test_reset_mid;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
